// File: rtl/bbox_overlay_renderer_pkg.sv
// Shared constants and types for the bounding-box overlay renderer.
package bbox_overlay_renderer_pkg;

  localparam int unsigned H_ACT     = 640;
  localparam int unsigned V_ACT     = 480;
  localparam int unsigned BORDER    = 2;
  localparam int unsigned CROSS_LEN = 6;
  localparam int unsigned LOST_W    = 4;
  localparam int unsigned BLINK_FRM = 15;
  localparam int unsigned N_REGION  = 16;

  localparam int unsigned CW    = 12;  // tracker box coordinate width
  localparam int unsigned PW    = 10;  // pixel coordinate width
  localparam int unsigned RGB_W = 16;
  localparam int unsigned FRM_W = $clog2(BLINK_FRM);
  localparam int unsigned CNT_W = $clog2(N_REGION + 1);

  localparam logic [RGB_W-1:0] RGB_CROSS = 16'hFFFF;
  localparam logic [RGB_W-1:0] RGB_LOST  = 16'hFFE0;
  localparam logic [RGB_W-1:0] RGB_EDGE  = 16'h07E0;

  typedef struct packed {
    logic [CW-1:0] x_min;
    logic [CW-1:0] x_max;
    logic [CW-1:0] y_min;
    logic [CW-1:0] y_max;
    logic [PW-1:0] aim_x;
    logic [PW-1:0] aim_y;
    logic          valid;
  } region_box_t;

  // A region is drawable only when detected and its bounds are ordered
  function automatic logic box_ok(input logic det, input region_box_t b);
    return det && (b.x_min <= b.x_max) && (b.y_min <= b.y_max);
  endfunction

endpackage

// File: rtl/bbox_overlay_renderer_hit_unit.sv
// Per-region hit test: registered box-outline and crosshair hits for the current pixel.
module bbox_overlay_renderer_hit_unit
  import bbox_overlay_renderer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] x,
  input  logic [PW-1:0] y,
  input  region_box_t   box,
  output logic          edge_hit,
  output logic          cross_hit
);

  localparam logic signed [CW:0] ARM = $signed((CW + 1)'(CROSS_LEN));

  logic [CW-1:0]        x_c, y_c, ax_c, ay_c;
  logic signed [CW:0]   dx_c, dy_c;
  logic                 inside_c, near_c, edge_c, cross_c;

  // Outline and crosshair tests in 12/13-bit arithmetic so nothing wraps at screen edges
  always_comb begin
    x_c      = CW'(x);
    y_c      = CW'(y);
    ax_c     = CW'(box.aim_x);
    ay_c     = CW'(box.aim_y);
    dx_c     = $signed({1'b0, x_c}) - $signed({1'b0, ax_c});
    dy_c     = $signed({1'b0, y_c}) - $signed({1'b0, ay_c});
    inside_c = (x_c >= box.x_min) && (x_c <= box.x_max) &&
               (y_c >= box.y_min) && (y_c <= box.y_max);
    near_c   = ((x_c - box.x_min) < CW'(BORDER)) || ((box.x_max - x_c) < CW'(BORDER)) ||
               ((y_c - box.y_min) < CW'(BORDER)) || ((box.y_max - y_c) < CW'(BORDER));
    edge_c   = box.valid && inside_c && near_c;
    cross_c  = box.valid &&
               (((y == box.aim_y) && (dx_c >= -ARM) && (dx_c <= ARM)) ||
                ((x == box.aim_x) && (dy_c >= -ARM) && (dy_c <= ARM)));
  end

  // Stage-1 hit registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      edge_hit  <= 1'b0;
      cross_hit <= 1'b0;
    end else begin
      edge_hit  <= edge_c;
      cross_hit <= cross_c;
    end
  end

endmodule

// File: rtl/bbox_overlay_renderer.sv
// Overlays tracker boxes, crosshairs and a blinking target-lost frame onto the VGA stream.
module bbox_overlay_renderer
  import bbox_overlay_renderer_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          v_sync,
  input  logic                          DE,
  input  logic [PW-1:0]                 x_pixel,
  input  logic [PW-1:0]                 y_pixel,
  input  logic [RGB_W-1:0]              cam_data,
  input  logic [N_REGION-1:0][CW-1:0]   x_min_all,
  input  logic [N_REGION-1:0][CW-1:0]   x_max_all,
  input  logic [N_REGION-1:0][CW-1:0]   y_min_all,
  input  logic [N_REGION-1:0][CW-1:0]   y_max_all,
  input  logic [N_REGION-1:0][PW-1:0]   aim_x_all,
  input  logic [N_REGION-1:0][PW-1:0]   aim_y_all,
  input  logic [N_REGION-1:0]           aim_detected_all,
  input  logic                          target_off,
  input  logic                          overlay_en,
  output logic [RGB_W-1:0]              out_data,
  output logic                          out_DE,
  output logic                          out_v_sync,
  output logic [PW-1:0]                 out_x,
  output logic [PW-1:0]                 out_y,
  output logic [CNT_W-1:0]              box_count
);

  logic                vs_d, vs_rise_c, snap_load;
  region_box_t         snap       [N_REGION];
  region_box_t         load_box_c [N_REGION];
  logic [CNT_W-1:0]    load_cnt_c;
  logic [FRM_W-1:0]    frame_cnt;
  logic                blink_phase;
  logic [N_REGION-1:0] edge_hits, cross_hits;
  logic                lost_c;
  logic                de_s1, vs_s1, en_s1, lost_s1;
  logic [PW-1:0]       x_s1, y_s1;
  logic [RGB_W-1:0]    cam_s1, pix_c;

  assign vs_rise_c = v_sync && !vs_d;

  // v_sync edge detect; the snapshot is taken the cycle after the detect cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      vs_d      <= 1'b0;
      snap_load <= 1'b0;
    end else begin
      vs_d      <= v_sync;
      snap_load <= vs_rise_c;
    end
  end

  // Gather incoming region sets with their validity and count the drawable ones
  always_comb begin
    load_cnt_c = '0;
    for (int i = 0; i < N_REGION; i++) begin
      load_box_c[i].x_min = x_min_all[i];
      load_box_c[i].x_max = x_max_all[i];
      load_box_c[i].y_min = y_min_all[i];
      load_box_c[i].y_max = y_max_all[i];
      load_box_c[i].aim_x = aim_x_all[i];
      load_box_c[i].aim_y = aim_y_all[i];
      load_box_c[i].valid = 1'b0;
      load_box_c[i].valid = box_ok(aim_detected_all[i], load_box_c[i]);
      load_cnt_c          = load_cnt_c + CNT_W'(load_box_c[i].valid);
    end
  end

  // Per-frame snapshot so the overlay never changes mid-frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_REGION; i++) snap[i] <= '0;
      box_count <= '0;
    end else if (snap_load) begin
      for (int i = 0; i < N_REGION; i++) snap[i] <= load_box_c[i];
      box_count <= load_cnt_c;
    end
  end

  // Blink counter for the target-lost frame; held visible while the target is present
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!target_off) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (vs_rise_c) begin
      if (frame_cnt == FRM_W'(BLINK_FRM - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FRM_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_REGION; g++) begin : g_region
    bbox_overlay_renderer_hit_unit u_hit (
      .clk       (clk),
      .reset     (reset),
      .x         (x_pixel),
      .y         (y_pixel),
      .box       (snap[g]),
      .edge_hit  (edge_hits[g]),
      .cross_hit (cross_hits[g])
    );
  end

  assign lost_c = target_off && blink_phase &&
                  ((x_pixel < PW'(LOST_W)) || (x_pixel >= PW'(H_ACT - LOST_W)) ||
                   (y_pixel < PW'(LOST_W)) || (y_pixel >= PW'(V_ACT - LOST_W)));

  // Stage-1 sideband and camera pixel registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      de_s1   <= 1'b0;
      vs_s1   <= 1'b0;
      en_s1   <= 1'b0;
      lost_s1 <= 1'b0;
      x_s1    <= '0;
      y_s1    <= '0;
      cam_s1  <= '0;
    end else begin
      de_s1   <= DE;
      vs_s1   <= v_sync;
      en_s1   <= overlay_en;
      lost_s1 <= lost_c;
      x_s1    <= x_pixel;
      y_s1    <= y_pixel;
      cam_s1  <= cam_data;
    end
  end

  // Colour priority: crosshair, lost frame, box edge, camera; black outside active video
  always_comb begin
    pix_c = cam_s1;
    if (!de_s1) begin
      pix_c = '0;
    end else if (en_s1) begin
      if (|cross_hits)     pix_c = RGB_CROSS;
      else if (lost_s1)    pix_c = RGB_LOST;
      else if (|edge_hits) pix_c = RGB_EDGE;
    end
  end

  // Stage-2 output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data   <= '0;
      out_DE     <= 1'b0;
      out_v_sync <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
    end else begin
      out_data   <= pix_c;
      out_DE     <= de_s1;
      out_v_sync <= vs_s1;
      out_x      <= x_s1;
      out_y      <= y_s1;
    end
  end

endmodule
